// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// Package : fp_pkg
// Shared IEEE-754 types and constants for the FP datapath (classify, FSM).
// Rev     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fp_pkg;

    typedef enum logic [2:0] {
        NORMALIZED   = 3'd0,
        DENORMALIZED = 3'd1,
        ZERO         = 3'd2,
        INFINITY     = 3'd3,
        NAN          = 3'd4
    } fp_class_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        DIV   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } div_state_t;

    localparam int          FP_BIAS = 127;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF = 32'h7F80_0000;

endpackage : fp_pkg

`default_nettype wire

// File: rtl/fp_unpack.sv
// ---------------------------------------------------------------------------
// Module : fp_unpack
// Splits a packed IEEE-754 word into sign/exponent/mantissa and classifies it.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_unpack
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] i_word,
    output logic                 o_sign,
    output logic [EXP_W-1:0]     o_exp,
    output logic [MAN_W:0]       o_man,
    output fp_class_t            o_class
);

    logic w_exp_zero;
    logic w_exp_ones;
    logic w_frac_zero;

    assign o_sign      = i_word[EXP_W+MAN_W];
    assign o_exp       = i_word[EXP_W+MAN_W-1:MAN_W];
    assign w_exp_zero  = (o_exp == '0);
    assign w_exp_ones  = (o_exp == '1);
    assign w_frac_zero = (i_word[MAN_W-1:0] == '0);
    assign o_man       = {~w_exp_zero, i_word[MAN_W-1:0]};

    always_comb begin
        o_class = NORMALIZED;
        if (w_exp_zero) begin
            o_class = w_frac_zero ? ZERO : DENORMALIZED;
        end else if (w_exp_ones) begin
            o_class = w_frac_zero ? INFINITY : NAN;
        end
    end

endmodule : fp_unpack

`default_nettype wire

// File: rtl/fp32_div_seq.sv
// ---------------------------------------------------------------------------
// Module : fp32_div_seq
// Iterative restoring IEEE-754 divider, one quotient bit per cycle, RNE, FTZ.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp32_div_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   div_by_zero,
    output logic                   invalid,
    output logic                   busy
);

    localparam int W      = EXP_W + MAN_W + 1;
    localparam int Q_BITS = MAN_W + 3;
    localparam int CNT_W  = $clog2(Q_BITS);
    localparam logic signed [EXP_W+1:0] c_BIAS = (EXP_W+2)'(2**(EXP_W-1) - 1);
    localparam logic signed [EXP_W+1:0] c_EMAX = (EXP_W+2)'(2**EXP_W - 1);
    localparam logic [CNT_W-1:0]        c_LAST = CNT_W'(Q_BITS - 1);
    localparam logic [W-1:0] c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-2:0] c_INF  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

    div_state_t r_state, w_state_nxt;

    logic [W-1:0]             r_a, r_b;
    logic                     r_sign;
    logic signed [EXP_W+1:0]  r_exp;
    logic [MAN_W+1:0]         r_rem;
    logic [MAN_W:0]           r_div;
    logic [Q_BITS-1:0]        r_q;
    logic [CNT_W-1:0]         r_cnt;
    logic [W-1:0]             r_result;
    logic                     r_ovf, r_unf, r_dbz, r_inv;

    logic                     w_sa, w_sb;
    logic [EXP_W-1:0]         w_ea, w_eb;
    logic [MAN_W:0]           w_ma, w_mb;
    fp_class_t                w_ca, w_cb;

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .i_word (r_a), .o_sign (w_sa), .o_exp (w_ea), .o_man (w_ma), .o_class (w_ca)
    );

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .i_word (r_b), .o_sign (w_sb), .o_exp (w_eb), .o_man (w_mb), .o_class (w_cb)
    );

    // Denormal operands are flushed, so they classify as zero here.
    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_any_nan, w_special, w_sign;
    assign w_a_zero  = (w_ca == ZERO) || (w_ca == DENORMALIZED);
    assign w_b_zero  = (w_cb == ZERO) || (w_cb == DENORMALIZED);
    assign w_a_inf   = (w_ca == INFINITY);
    assign w_b_inf   = (w_cb == INFINITY);
    assign w_any_nan = (w_ca == NAN) || (w_cb == NAN);
    assign w_special = w_any_nan || w_a_zero || w_b_zero || w_a_inf || w_b_inf;
    assign w_sign    = w_sa ^ w_sb;

    logic [W-1:0] w_sp_result;
    logic         w_sp_inv, w_sp_dbz;
    always_comb begin
        w_sp_result = {w_sign, c_INF};
        w_sp_inv    = 1'b0;
        w_sp_dbz    = 1'b0;
        if (w_any_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_sp_result = c_QNAN;
            w_sp_inv    = 1'b1;
        end else if (w_a_inf) begin
            w_sp_result = {w_sign, c_INF};
        end else if (w_b_inf || w_a_zero) begin
            w_sp_result = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_sp_dbz    = 1'b1;
        end
    end

    logic signed [EXP_W+1:0] w_exp_init;
    assign w_exp_init = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + c_BIAS;

    logic             w_ge;
    logic [MAN_W+1:0] w_rem_sub;
    assign w_ge      = (r_rem >= {1'b0, r_div});
    assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

    // Normalised quotient without its leading 1: fraction, guard, round.
    logic [Q_BITS-2:0]       w_qf;
    logic signed [EXP_W+1:0] w_en, w_ef;
    logic                    w_sticky, w_up, w_carry;
    logic [MAN_W-1:0]        w_frac;
    assign w_qf     = r_q[Q_BITS-1] ? r_q[Q_BITS-2:0] : {r_q[Q_BITS-3:0], 1'b0};
    assign w_en     = r_q[Q_BITS-1] ? r_exp : (r_exp - (EXP_W+2)'(1));
    assign w_sticky = (r_rem != '0);
    assign w_up     = w_qf[1] & (w_qf[0] | w_sticky | w_qf[2]);
    assign {w_carry, w_frac} = {1'b0, w_qf[Q_BITS-2:2]} + (MAN_W+1)'(w_up);
    assign w_ef     = w_en + $signed({{(EXP_W+1){1'b0}}, w_carry});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = SETUP;
            SETUP:   w_state_nxt = w_special ? DONE : DIV;
            DIV:     if (r_cnt == c_LAST) w_state_nxt = NORM;
            NORM:    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0; r_b <= '0; r_sign <= 1'b0; r_exp <= '0;
            r_rem <= '0; r_div <= '0; r_q <= '0; r_cnt <= '0;
            r_result <= '0;
            r_ovf <= 1'b0; r_unf <= 1'b0; r_dbz <= 1'b0; r_inv <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a <= a;
                    r_b <= b;
                    r_ovf <= 1'b0; r_unf <= 1'b0; r_dbz <= 1'b0; r_inv <= 1'b0;
                end
                SETUP: begin
                    r_sign <= w_sign;
                    r_exp  <= w_exp_init;
                    r_rem  <= {1'b0, w_ma};
                    r_div  <= w_mb;
                    r_q    <= '0;
                    r_cnt  <= '0;
                    if (w_special) begin
                        r_result <= w_sp_result;
                        r_inv    <= w_sp_inv;
                        r_dbz    <= w_sp_dbz;
                    end
                end
                DIV: begin
                    r_q   <= {r_q[Q_BITS-2:0], w_ge};
                    r_rem <= w_rem_sub << 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                NORM: begin
                    if (w_ef >= c_EMAX) begin
                        r_result <= {r_sign, c_INF};
                        r_ovf    <= 1'b1;
                    end else if (w_ef <= $signed((EXP_W+2)'(0))) begin
                        r_result <= {r_sign, {(W-1){1'b0}}};
                        r_unf    <= 1'b1;
                    end else begin
                        r_result <= {r_sign, w_ef[EXP_W-1:0], w_frac};
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign result      = r_result;
    assign overflow    = r_ovf;
    assign underflow   = r_unf;
    assign div_by_zero = r_dbz;
    assign invalid     = r_inv;

endmodule : fp32_div_seq

`default_nettype wire

// File: tb/tb_fp32_div_seq.sv
// ---------------------------------------------------------------------------
// Module : tb_fp32_div_seq
// Directed self-checking bench for the sequential FP32 divider.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fp32_div_seq;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        overflow, underflow, div_by_zero, invalid, busy;

    int total = 0;
    int bad   = 0;

    fp32_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
        .a (a), .b (b), .out_valid (out_valid), .out_ready (out_ready),
        .result (result), .overflow (overflow), .underflow (underflow),
        .div_by_zero (div_by_zero), .invalid (invalid), .busy (busy)
    );

    always #5 clk = ~clk;

    // flags are packed {overflow, underflow, div_by_zero, invalid}
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                          output logic [31:0] res, output logic [3:0] flg, output int lat);
        bit got = 0;
        @(negedge clk);
        a = ia; b = ib; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!got && lat < 100) begin
            @(negedge clk);
            if (out_valid) got = 1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        if (!got) lat = -1;
        res = result;
        flg = {overflow, underflow, div_by_zero, invalid};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
        total++; if ({overflow, underflow, div_by_zero, invalid} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {overflow, underflow, div_by_zero, invalid}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_normal();
        logic [31:0] va [4] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000};
        logic [31:0] vb [4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h3F7FFFFF};
        logic [31:0] ve [4] = '{32'h40400000, 32'h3EAAAAAB, 32'hBE800000, 32'h3F800001};
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], res, flg, lat);
            total++; if (res !== ve[i]) begin bad++; $display("FAIL normal_result[%0d] got=%h exp=%h", i, res, ve[i]); end
            total++; if (flg !== 4'b0000) begin bad++; $display("FAIL normal_flags[%0d] got=%b exp=0000", i, flg); end
            total++; if (lat !== 29) begin bad++; $display("FAIL normal_latency[%0d] got=%0d exp=29", i, lat); end
        end
    endtask

    task automatic test_special();
        logic [31:0] va [8] = '{32'h3F800000, 32'h00000000, 32'h80000000, 32'h7FC00000,
                                32'h7F800000, 32'hFF800000, 32'h40000000, 32'h00000001};
        logic [31:0] vb [8] = '{32'h00000000, 32'h00000000, 32'h40A00000, 32'h3F800000,
                                32'h7F800000, 32'h40000000, 32'hFF800000, 32'h3F800000};
        logic [31:0] ve [8] = '{FP_PINF, FP_QNAN, 32'h80000000, FP_QNAN,
                                FP_QNAN, 32'hFF800000, 32'h80000000, 32'h00000000};
        logic [3:0]  vf [8] = '{4'b0010, 4'b0001, 4'b0000, 4'b0001,
                                4'b0001, 4'b0000, 4'b0000, 4'b0000};
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            run_op(va[i], vb[i], res, flg, lat);
            total++; if (res !== ve[i]) begin bad++; $display("FAIL special_result[%0d] got=%h exp=%h", i, res, ve[i]); end
            total++; if (flg !== vf[i]) begin bad++; $display("FAIL special_flags[%0d] got=%b exp=%b", i, flg, vf[i]); end
            total++; if (lat !== 2) begin bad++; $display("FAIL special_latency[%0d] got=%0d exp=2", i, lat); end
        end
    endtask

    task automatic test_range();
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        run_op(32'h7F000000, 32'h3E800000, res, flg, lat);
        total++; if (res !== 32'h7F800000) begin bad++; $display("FAIL overflow_result got=%h exp=7f800000", res); end
        total++; if (flg !== 4'b1000) begin bad++; $display("FAIL overflow_flags got=%b exp=1000", flg); end
        run_op(32'h00800000, 32'h40000000, res, flg, lat);
        total++; if (res !== 32'h00000000) begin bad++; $display("FAIL underflow_result got=%h exp=00000000", res); end
        total++; if (flg !== 4'b0100) begin bad++; $display("FAIL underflow_flags got=%b exp=0100", flg); end
    endtask

    task automatic test_handshake();
        int  lat = 0;
        bit  got = 0;
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            if (out_valid) got = 1;
            else lat++;
        end
        total++; if (!got) begin bad++; $display("FAIL hs_wait_valid got=timeout exp=out_valid"); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || result !== 32'h40400000 || in_ready !== 1'b0) begin
                bad++; $display("FAIL hs_hold[%0d] got=v%b r=%h rdy=%b exp=v1 r=40400000 rdy=0",
                                i, out_valid, result, in_ready);
            end
        end
        a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++; $display("FAIL hs_no_accept got=rdy%b v%b exp=rdy0 v1", in_ready, out_valid); end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL hs_idle got=rdy%b busy%b v%b exp=rdy1 busy0 v0", in_ready, busy, out_valid); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL hs_accept got=busy%b rdy%b exp=busy1 rdy0", busy, in_ready); end
        out_ready = 1'b1;
        got = 0; lat = 1;
        while (!got && lat < 100) begin
            @(negedge clk);
            if (out_valid) got = 1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        total++; if (lat !== 29) begin bad++; $display("FAIL hs_second_latency got=%0d exp=29", lat); end
        total++; if (result !== 32'h3EAAAAAB) begin bad++; $display("FAIL hs_second_result got=%h exp=3eaaaaab", result); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", busy); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_reset got=rdy%b v%b busy%b exp=rdy1 v0 busy0", in_ready, out_valid, busy); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL mid_reset_result got=%h exp=0", result); end
        @(negedge clk);
        rst = 1'b0;
        run_op(32'hBF800000, 32'h40800000, res, flg, lat);
        total++; if (res !== 32'hBE800000 || lat !== 29) begin
            bad++; $display("FAIL mid_after got=%h lat=%0d exp=be800000 lat=29", res, lat); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_range();
        test_handshake();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fp32_div_seq

`default_nettype wire
